mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage directly downstream of the address generation unit. Accepts one memory micro-op per transaction: effective address, size and misalign flag from AGU, plus store data. Issues a single request/acknowledge transaction to the data-memory port, aligns and extends load data, and hands one result to writeback. Misaligned accesses never reach memory; they retire with an exception flag.

## Interface
Parameters:
- XLEN, 64, data/address width; equals the width of reg_data_t

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_log_fd  in  32  trace file descriptor; simulation only
- i_e  in  1  op valid from AGU stage
- o_ready  out  1  stage can accept; i_e is taken on i_e & o_ready
- i_op  in  decode_mem_op_t  OP_MEM_LD (sign-extend), OP_MEM_LDU (zero-extend), OP_MEM_ST
- i_addr  in  reg_data_t  effective address (AGU o_dest)
- i_size  in  2  0=B, 1=H, 2=W, 3=D
- i_misalign  in  1  AGU misalign flag
- i_st_data  in  reg_data_t  store data, right-justified
- i_flush  in  1  squash the in-flight op
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1=store
- o_dmem_addr  out  reg_data_t  address with bits [2:0] cleared
- o_dmem_be  out  8  byte enables
- o_dmem_wdata  out  reg_data_t  lane-replicated store data
- i_dmem_ack  in  1  completes the request; i_dmem_rdata is valid in the same cycle
- i_dmem_rdata  in  reg_data_t  aligned doubleword
- o_valid  out  1  result valid, one-cycle pulse
- o_data  out  reg_data_t  extended load data; 0 for stores and faults
- o_misalign  out  1  exception qualifier; meaningful with o_valid

## Operation
- States: IDLE, REQ, DRAIN, DONE.
- IDLE: o_ready=1. Accept on i_e with no i_flush in the same cycle. Latch op, addr, size and store data.
  - If i_misalign: go to DONE with the fault flag set.
  - Otherwise: go to REQ.
- REQ: o_dmem_req=1. Hold all o_dmem_* stable until i_dmem_ack.
  - On ack: latch the aligned and extended load data, then go to DONE.
  - On i_flush without ack: go to DRAIN.
  - On i_flush with ack in the same cycle: go to IDLE and emit no result.
- DRAIN: keep o_dmem_req=1 with unchanged fields, because a request is never withdrawn. On ack, go to IDLE. No o_valid.
- DONE: o_valid=1 for one cycle. Go to IDLE.
  - If i_flush is high, suppress o_valid.
- Byte-enable mask: 8'h01<<a, 8'h03<<a, 8'h0F<<a or 8'hFF for B, H, W and D, where a=addr[2:0].
- Store data: the low 2^size bytes are replicated across all lanes.
- Load data: rdata>>(8*a), truncated to the size, then sign-extended for LD or zero-extended for LDU.
- Reset at any point returns the FSM to IDLE. No handshake is preserved across reset.

## Timing
- Reset values: o_ready=1; all other outputs are 0 (o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata, o_valid, o_data, o_misalign).
- Accept in cycle 0. o_dmem_req is high from cycle 1. If ack arrives in cycle k≥1, o_valid is high in cycle k+1.
  - Minimum load/store latency: 2 cycles from accept to o_valid.
- Misaligned op accepted in cycle 0: o_valid=1 and o_misalign=1 in cycle 1. o_dmem_req never asserts.
- o_ready is 0 in REQ, DRAIN and DONE. Back-to-back throughput is one op per 3 cycles at zero memory wait.
- o_data and o_misalign are registered. o_dmem_* are registered from latched state, so there is no combinational input-to-output path.

## Structure
- Shared package (mem_pkg):
  - mau_state_t enum
  - size encodings MEM_SZ_B/H/W/D
  - byte-enable base constants
- decode_mem_op_t and reg_data_t come from the existing instruction/config includes.
- One combinational sub-module, mem_lane_align. It takes addr[2:0], size, op, st_data and rdata, and produces be, wdata and extended load data.
- The FSM and registers live in mem_access_unit.

## Test plan
- LD, size=0, addr=0x1003, rdata=0x0000_0000_8000_0000 -> dmem_addr=0x1000, be=0x08, o_data=0xFFFF_FFFF_FFFF_FF80, o_valid in cycle 2.
- LDU, size=1, addr=0x2006, rdata=0xBEEF_0000_0000_0000, ack delayed 4 cycles -> req held stable 4 cycles, o_data=0x0000_0000_0000_BEEF.
- ST, size=2, addr=0x3004, st_data=0x1122_3344 -> we=1, be=0xF0, wdata=0x1122_3344_1122_3344, o_data=0, o_valid one cycle after ack.
- Misaligned W at 0x4002 -> no o_dmem_req, o_valid=1 with o_misalign=1 in cycle 1, o_ready=1 in cycle 2.
- Flush in REQ before ack, ack 3 cycles later -> req stays high through ack, no o_valid, o_ready returns the cycle after ack.
- i_rst asserted while waiting in REQ -> all outputs 0 and o_ready=1 immediately; a new op is accepted after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

  localparam int unsigned XLEN_W = 64;

  typedef logic [XLEN_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    OP_MEM_LD  = 2'd0,
    OP_MEM_LDU = 2'd1,
    OP_MEM_ST  = 2'd2
  } decode_mem_op_t;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_REQ,
    MAU_DRAIN,
    MAU_DONE
  } mau_state_t;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;
  localparam logic [1:0] MEM_SZ_D = 2'd3;

  localparam logic [7:0] BE_BASE_B = 8'h01;
  localparam logic [7:0] BE_BASE_H = 8'h03;
  localparam logic [7:0] BE_BASE_W = 8'h0F;
  localparam logic [7:0] BE_BASE_D = 8'hFF;

  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] a);
    logic [7:0] m;
    case (size)
      MEM_SZ_B: m = BE_BASE_B << a;
      MEM_SZ_H: m = BE_BASE_H << a;
      MEM_SZ_W: m = BE_BASE_W << a;
      default:  m = BE_BASE_D;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// AGU-side, data-memory and writeback signals of the memory-access stage.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic           i_e;
  logic           o_ready;
  decode_mem_op_t i_op;
  reg_data_t      i_addr;
  logic [1:0]     i_size;
  logic           i_misalign;
  reg_data_t      i_st_data;
  logic           i_flush;

  logic           o_dmem_req;
  logic           o_dmem_we;
  reg_data_t      o_dmem_addr;
  logic [7:0]     o_dmem_be;
  reg_data_t      o_dmem_wdata;
  logic           i_dmem_ack;
  reg_data_t      i_dmem_rdata;

  logic           o_valid;
  reg_data_t      o_data;
  logic           o_misalign;

  modport slave (
    input  i_e, i_op, i_addr, i_size, i_misalign, i_st_data, i_flush,
           i_dmem_ack, i_dmem_rdata,
    output o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
           o_valid, o_data, o_misalign
  );

  modport master (
    output i_e, i_op, i_addr, i_size, i_misalign, i_st_data, i_flush,
           i_dmem_ack, i_dmem_rdata,
    input  o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
           o_valid, o_data, o_misalign
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication, byte enables and load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]     addr_lo,
  input  logic [1:0]     size,
  input  decode_mem_op_t op,
  input  reg_data_t      st_data,
  input  reg_data_t      rdata,
  output logic [7:0]     be,
  output reg_data_t      wdata,
  output reg_data_t      ld_data
);

  reg_data_t shifted;
  logic      sext;

  always_comb begin
    be      = be_mask(size, addr_lo);
    shifted = rdata >> {addr_lo, 3'b000};
    sext    = (op == OP_MEM_LD);
    wdata   = '0;
    ld_data = '0;
    case (size)
      MEM_SZ_B: begin
        wdata   = {8{st_data[7:0]}};
        ld_data = {{56{sext & shifted[7]}}, shifted[7:0]};
      end
      MEM_SZ_H: begin
        wdata   = {4{st_data[15:0]}};
        ld_data = {{48{sext & shifted[15]}}, shifted[15:0]};
      end
      MEM_SZ_W: begin
        wdata   = {2{st_data[31:0]}};
        ld_data = {{32{sext & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        wdata   = st_data;
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one dmem transaction per op, aligned/extended result to writeback.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_log_fd,
  mem_access_unit_if.slave     bus
);

  mau_state_t     state, state_nxt;
  decode_mem_op_t op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] st_q;
  logic [XLEN-1:0] data_q;
  logic [1:0]     size_q;
  logic           mis_q;

  logic           accept;
  logic           busy_req;
  logic [7:0]     be;
  reg_data_t      wdata;
  reg_data_t      ld_data;

  // Trace descriptor is only meaningful to simulation-side logging.
  logic unused_log;
  assign unused_log = ^i_log_fd;

  mem_lane_align u_align (
    .addr_lo (addr_q[2:0]),
    .size    (size_q),
    .op      (op_q),
    .st_data (st_q),
    .rdata   (bus.i_dmem_rdata),
    .be      (be),
    .wdata   (wdata),
    .ld_data (ld_data)
  );

  assign accept   = (state == MAU_IDLE) && bus.i_e && !bus.i_flush;
  assign busy_req = (state == MAU_REQ) || (state == MAU_DRAIN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      MAU_IDLE:  if (accept) state_nxt = bus.i_misalign ? MAU_DONE : MAU_REQ;
      MAU_REQ: begin
        if (bus.i_dmem_ack)   state_nxt = bus.i_flush ? MAU_IDLE : MAU_DONE;
        else if (bus.i_flush) state_nxt = MAU_DRAIN;
      end
      MAU_DRAIN: if (bus.i_dmem_ack) state_nxt = MAU_IDLE;
      MAU_DONE:  state_nxt = MAU_IDLE;
      default:   state_nxt = MAU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= MAU_IDLE;
      op_q   <= OP_MEM_LD;
      addr_q <= '0;
      st_q   <= '0;
      size_q <= '0;
      data_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= bus.i_op;
        addr_q <= bus.i_addr;
        st_q   <= bus.i_st_data;
        size_q <= bus.i_size;
        data_q <= '0;
        mis_q  <= bus.i_misalign;
      end else if ((state == MAU_REQ) && bus.i_dmem_ack && !bus.i_flush) begin
        data_q <= (op_q == OP_MEM_ST) ? '0 : ld_data;
      end
    end
  end

  // Memory fields come only from latched state and read as zero outside a request.
  assign bus.o_ready      = (state == MAU_IDLE);
  assign bus.o_dmem_req   = busy_req;
  assign bus.o_dmem_we    = busy_req && (op_q == OP_MEM_ST);
  assign bus.o_dmem_addr  = busy_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign bus.o_dmem_be    = busy_req ? be : '0;
  assign bus.o_dmem_wdata = busy_req ? wdata : '0;
  assign bus.o_valid      = (state == MAU_DONE) && !bus.i_flush;
  assign bus.o_data       = data_q;
  assign bus.o_misalign   = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-level reference model and per-cycle compare.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.XLEN(64)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_log_fd (32'd0),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // expected outputs for the current cycle, set by the driver
  logic        e_ready, e_req, e_we, e_valid, e_mis, e_zero;
  logic [63:0] e_addr, e_wdata, e_data;
  logic [7:0]  e_be;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // reference model: byte arithmetic straight from the lane rules
  function automatic logic [7:0] m_be(input int size, input int a);
    logic [15:0] m;
    int n;
    if (size == 3) return 8'hFF;
    n = 1 << size;
    m = ((16'd1 << n) - 16'd1) << a;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input int size, input logic [63:0] st);
    logic [63:0] r;
    int n;
    n = 1 << size;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = st[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input decode_mem_op_t op, input int size,
                                         input int a, input logic [63:0] rd);
    logic [63:0] r;
    int n;
    n = 1 << size;
    r = '0;
    for (int i = 0; i < n; i++)
      if (a + i < 8) r[8*i +: 8] = rd[8*(a+i) +: 8];
    if (op == OP_MEM_LD && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  always @(negedge clk) begin
    chk("ready", {63'd0, bus.o_ready}, {63'd0, e_ready});
    chk("req",   {63'd0, bus.o_dmem_req}, {63'd0, e_req});
    chk("valid", {63'd0, bus.o_valid}, {63'd0, e_valid});
    if (e_req) begin
      chk("we",   {63'd0, bus.o_dmem_we}, {63'd0, e_we});
      chk("addr", bus.o_dmem_addr, e_addr);
      chk("be",   {56'd0, bus.o_dmem_be}, {56'd0, e_be});
      if (e_we) chk("wdata", bus.o_dmem_wdata, e_wdata);
    end
    if (e_valid) begin
      chk("data", bus.o_data, e_data);
      chk("mis",  {63'd0, bus.o_misalign}, {63'd0, e_mis});
    end
    if (e_zero) begin
      chk("rst_we",    {63'd0, bus.o_dmem_we}, 64'd0);
      chk("rst_addr",  bus.o_dmem_addr, 64'd0);
      chk("rst_be",    {56'd0, bus.o_dmem_be}, 64'd0);
      chk("rst_wdata", bus.o_dmem_wdata, 64'd0);
      chk("rst_data",  bus.o_data, 64'd0);
      chk("rst_mis",   {63'd0, bus.o_misalign}, 64'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    e_ready = 1'b1; e_req = 1'b0; e_valid = 1'b0; e_zero = 1'b0;
  endtask

  task automatic drive_accept(input decode_mem_op_t op, input logic [63:0] addr, input int size,
                              input bit mis, input logic [63:0] st);
    bus.i_e = 1'b1; bus.i_op = op; bus.i_addr = addr; bus.i_size = size[1:0];
    bus.i_misalign = mis; bus.i_st_data = st;
    set_idle();
    tick();
    // scramble the AGU inputs so the DUT must rely on its latched copy
    bus.i_e = 1'b0; bus.i_addr = ~addr; bus.i_st_data = ~st; bus.i_size = ~size[1:0];
    bus.i_misalign = 1'b0;
  endtask

  task automatic set_req(input decode_mem_op_t op, input logic [63:0] addr, input int size,
                         input logic [63:0] st);
    e_ready = 1'b0; e_req = 1'b1; e_valid = 1'b0;
    e_we    = (op == OP_MEM_ST);
    e_addr  = {addr[63:3], 3'b000};
    e_be    = m_be(size, int'(addr[2:0]));
    e_wdata = m_wdata(size, st);
  endtask

  task automatic do_op(input decode_mem_op_t op, input logic [63:0] addr, input int size,
                       input bit mis, input logic [63:0] st, input logic [63:0] rd,
                       input int wt, input bit flush_done, input bit lit_en,
                       input logic [63:0] lit_data);
    drive_accept(op, addr, size, mis, st);
    if (mis) begin
      e_ready = 1'b0; e_req = 1'b0; e_valid = 1'b1; e_mis = 1'b1; e_data = '0;
      tick();
      set_idle();
      return;
    end
    set_req(op, addr, size, st);
    for (int j = 0; j <= wt; j++) begin
      bus.i_dmem_ack   = (j == wt);
      bus.i_dmem_rdata = (j == wt) ? rd : {$urandom, $urandom};
      tick();
    end
    bus.i_dmem_ack = 1'b0;
    bus.i_dmem_rdata = {$urandom, $urandom};
    bus.i_flush = flush_done;
    e_req = 1'b0; e_valid = !flush_done; e_mis = 1'b0;
    e_data = (op == OP_MEM_ST) ? 64'd0 : m_load(op, size, int'(addr[2:0]), rd);
    if (lit_en) begin
      #5;
      chk("lit_data", bus.o_data, lit_data);
    end
    tick();
    bus.i_flush = 1'b0;
    set_idle();
  endtask

  // flush while the request is outstanding; ack_now puts the ack in the flush cycle
  task automatic do_flush_req(input logic [63:0] addr, input int wt, input bit ack_now);
    drive_accept(OP_MEM_LD, addr, 3, 1'b0, 64'd0);
    set_req(OP_MEM_LD, addr, 3, 64'd0);
    bus.i_flush = 1'b1;
    bus.i_dmem_ack = ack_now;
    tick();
    bus.i_flush = 1'b0;
    if (!ack_now) begin
      for (int j = 1; j <= wt; j++) begin
        bus.i_dmem_ack = (j == wt);
        tick();
      end
    end
    bus.i_dmem_ack = 1'b0;
    set_idle();
    tick();
  endtask

  initial begin
    bus.i_e = 1'b0; bus.i_op = OP_MEM_LD; bus.i_addr = '0; bus.i_size = '0;
    bus.i_misalign = 1'b0; bus.i_st_data = '0; bus.i_flush = 1'b0;
    bus.i_dmem_ack = 1'b0; bus.i_dmem_rdata = '0;
    e_we = 1'b0; e_mis = 1'b0; e_addr = '0; e_wdata = '0; e_data = '0; e_be = '0;
    set_idle();
    e_zero = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e_zero = 1'b0;

    // hand-computed anchors for the model
    chk("pin_ld_b",  m_load(OP_MEM_LD, 0, 3, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_ldu_h", m_load(OP_MEM_LDU, 1, 6, 64'hBEEF_0000_0000_0000), 64'h0000_0000_0000_BEEF);
    chk("pin_be_w",  {56'd0, m_be(2, 4)}, 64'h0000_0000_0000_00F0);
    chk("pin_be_b",  {56'd0, m_be(0, 3)}, 64'h0000_0000_0000_0008);
    chk("pin_wd_w",  m_wdata(2, 64'h1122_3344), 64'h1122_3344_1122_3344);

    do_op(OP_MEM_LD,  64'h1003, 0, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(OP_MEM_LDU, 64'h2006, 1, 1'b0, 64'd0, 64'hBEEF_0000_0000_0000, 3, 1'b0, 1'b1, 64'h0000_0000_0000_BEEF);
    do_op(OP_MEM_ST,  64'h3004, 2, 1'b0, 64'h1122_3344, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b0, 1'b1, 64'd0);
    do_op(OP_MEM_LD,  64'h4002, 2, 1'b1, 64'd0, 64'd0, 0, 1'b0, 1'b0, 64'd0);
    do_op(OP_MEM_LD,  64'h5000, 3, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
    do_op(OP_MEM_LD,  64'h6004, 2, 1'b0, 64'd0, 64'h8000_0001_0000_0000, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001);
    do_op(OP_MEM_LDU, 64'h7007, 0, 1'b0, 64'd0, 64'hFF00_0000_0000_0000, 2, 1'b0, 1'b1, 64'h0000_0000_0000_00FF);
    do_op(OP_MEM_LD,  64'h7806, 1, 1'b0, 64'd0, 64'h8001_0000_0000_0000, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
    do_op(OP_MEM_ST,  64'h8005, 0, 1'b0, 64'h0000_0000_0000_00AB, 64'd0, 0, 1'b0, 1'b0, 64'd0);
    do_op(OP_MEM_ST,  64'h9000, 3, 1'b0, 64'hCAFE_F00D_1234_5678, 64'd0, 1, 1'b0, 1'b0, 64'd0);

    do_flush_req(64'hA008, 3, 1'b0);
    do_flush_req(64'hB010, 0, 1'b1);
    do_op(OP_MEM_LD, 64'hC001, 0, 1'b0, 64'd0, 64'h0000_0000_0000_7F00, 0, 1'b1, 1'b0, 64'd0);

    // op offered together with flush must not be taken
    bus.i_e = 1'b1; bus.i_flush = 1'b1; bus.i_addr = 64'hD000; bus.i_misalign = 1'b0;
    set_idle();
    tick();
    bus.i_e = 1'b0; bus.i_flush = 1'b0;
    tick();

    // reset while waiting for ack
    drive_accept(OP_MEM_ST, 64'hE003, 0, 1'b0, 64'h55);
    set_req(OP_MEM_ST, 64'hE003, 0, 64'h55);
    tick();
    rst = 1'b1;
    set_idle();
    e_zero = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    e_zero = 1'b0;
    do_op(OP_MEM_LDU, 64'hF004, 2, 1'b0, 64'd0, 64'h8765_4321_0000_0000, 0, 1'b0, 1'b1, 64'h0000_0000_8765_4321);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
